// File: rtl/sequence_detector_param.sv
// Run-time programmable serial bit-pattern detector with a registered one-cycle match pulse.
// Optional saturating match counter is built when SEQ_DET_MATCH_COUNT_EN is defined.
module sequence_detector_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 CNT_W         = 16,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 RESET_LEN     = 4,
  parameter bit                 RESET_OVERLAP = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sequence_in,
  input  logic                       in_valid,
  input  logic                       cfg_load,
  input  logic [MAX_LEN-1:0]         cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]   cfg_len,
  input  logic                       cfg_overlap,
  output logic                       detector_out,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           match_count
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  typedef enum logic {FILL = 1'b0, HUNT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_ok;
  logic               match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      pat_q   <= RESET_PATTERN;
      len_q   <= LEN_W'(RESET_LEN);
      ovl_q   <= RESET_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    det_d    = 1'b0;
    err_d    = err_q;
    match    = 1'b0;
    shifted  = {hist_q[MAX_LEN-2:0], sequence_in};
    // In HUNT the window is already full, so fill stays pinned at len.
    fill_inc = (state_q == HUNT) ? fill_q : fill_q + LEN_W'(1);
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end

    if (cfg_load && cfg_ok) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      err_d   = 1'b0;
      state_d = FILL;
    end else begin
      if (cfg_load) begin
        err_d = 1'b1;
      end
      if (in_valid) begin
        hist_d = shifted;
        fill_d = fill_inc;
        match  = (fill_inc == len_q) && (((shifted ^ pat_q) & mask) == '0);
        case (state_q)
          FILL:    if (fill_inc == len_q) state_d = HUNT;
          default: state_d = HUNT;
        endcase
        if (match) begin
          det_d = 1'b1;
          if (!ovl_q) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
      end
    end
  end

  assign detector_out = det_q;
  assign cfg_err      = err_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cfg_load && cfg_ok) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_sequence_detector_param.sv
// Directed plus randomized bench for sequence_detector_param, checked against a
// queue-based model of the bits received since the last clear.
module tb_sequence_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int W       = 2 + CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               sequence_in = 1'b0;
  logic               in_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               detector_out;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  sequence_detector_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sequence_in (sequence_in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .detector_out(detector_out),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard: expected {detector_out, cfg_err, match_count} per edge
  logic [W-1:0] exp_q[$];

  // reference model
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_err;
  int         m_cnt;
  bit         win_q[$];

  task automatic model_reset();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_ovl = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    win_q.delete();
  endtask

  task automatic model_edge(input logic ld, input logic [7:0] p, input logic [LEN_W-1:0] l,
                            input logic o, input logic v, input logic b);
    bit det;
    bit hit;
    int n;
    det = 1'b0;
    if (ld && (int'(l) >= 1) && (int'(l) <= MAX_LEN)) begin
      m_pat = p;
      m_len = int'(l);
      m_ovl = o;
      m_err = 1'b0;
      m_cnt = 0;
      win_q.delete();
    end else begin
      if (ld) m_err = 1'b1;
      if (v) begin
        win_q.push_back(b);
        if (win_q.size() > MAX_LEN) void'(win_q.pop_front());
        n = win_q.size();
        hit = (n >= m_len);
        if (hit) begin
          for (int k = 0; k < m_len; k++) begin
            if (win_q[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
          end
        end
        if (hit) begin
          det = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) win_q.delete();
        end
      end
    end
`ifdef SEQ_DET_MATCH_COUNT_EN
    exp_q.push_back({det, m_err, CNT_W'(m_cnt)});
`else
    exp_q.push_back({det, m_err, CNT_W'(0)});
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert ({detector_out, cfg_err, match_count} === e)
    else begin
      miscompares++;
      $error("FAIL %s: observed det/err/cnt=%b required=%b", tag,
             {detector_out, cfg_err, match_count}, e);
    end
  endtask

  task automatic expect_det(input logic e, input string tag);
    vectors++;
    assert (detector_out === e)
    else begin
      miscompares++;
      $error("FAIL %s: observed detector_out=%b required=%b", tag, detector_out, e);
    end
  endtask

  task automatic expect_cnt(input int e, input string tag);
    vectors++;
    assert (match_count === CNT_W'(e))
    else begin
      miscompares++;
      $error("FAIL %s: observed match_count=%0d required=%0d", tag, match_count, e);
    end
  endtask

  // driver tasks
  task automatic step(input logic ld, input logic [7:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic v, input logic b, input string tag);
    cfg_load    = ld;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    in_valid    = v;
    sequence_in = b;
    @(posedge clock);
    model_edge(ld, p, l, o, v, b);
    #1;
    check_outputs(tag);
  endtask

  task automatic bit_in(input logic b, input string tag);
    step(1'b0, 8'h00, '0, 1'b0, 1'b1, b, tag);
  endtask

  task automatic gap(input string tag);
    step(1'b0, 8'h00, '0, 1'b0, 1'b0, $urandom_range(0, 1), tag);
  endtask

  task automatic load(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic o,
                      input string tag);
    step(1'b1, p, l, o, 1'b0, 1'b0, tag);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i], tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectors++;
    assert ({detector_out, cfg_err, match_count} === '0)
    else begin
      miscompares++;
      $error("FAIL async_reset: observed det/err/cnt=%b required=0",
             {detector_out, cfg_err, match_count});
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // reset held with toggling stream
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid    = 1'b1;
      sequence_in = i[0];
      @(posedge clock);
      #1;
      vectors++;
      assert ({detector_out, cfg_err, match_count} === '0)
      else begin
        miscompares++;
        $error("FAIL reset_hold: observed det/err/cnt=%b required=0",
               {detector_out, cfg_err, match_count});
      end
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // default pattern 1011
    send_bits(16'b1011, 4, "default_1011");
    expect_det(1'b1, "default_pulse");
`ifdef SEQ_DET_MATCH_COUNT_EN
    expect_cnt(1, "default_count");
`else
    expect_cnt(0, "default_count_off");
`endif
    gap("default_after");
    expect_det(1'b0, "default_single");

    // overlap vs non-overlap
    load(8'b0000_1011, 4, 1'b1, "load_ovl");
    send_bits(16'b1011011, 7, "ovl_stream");
    load(8'b0000_1011, 4, 1'b0, "load_novl");
    send_bits(16'b1011011, 7, "novl_stream");

    // 8-bit reload, illegal reloads
    load(8'b1100_0110, 8, 1'b1, "load_8bit");
    send_bits(16'b1100_0110, 8, "byte_stream");
    expect_det(1'b1, "byte_pulse");
    load(8'b0000_0001, 9, 1'b1, "load_len9");
    send_bits(16'b1100_0110, 8, "byte_after_err");
    expect_det(1'b1, "byte_pulse_after_err");
    load(8'b0000_0001, 0, 1'b1, "load_len0");
    gap("err_sticky");

    // valid gaps
    load(8'b0000_1011, 4, 1'b1, "load_gaps");
    bit_in(1'b1, "gap_seq");
    gap("gap_1");
    bit_in(1'b0, "gap_seq");
    bit_in(1'b1, "gap_seq");
    gap("gap_2");
    gap("gap_3");
    gap("gap_4");
    bit_in(1'b1, "gap_final");
    expect_det(1'b1, "gap_pulse");
    gap("gap_tail");

    // mid-operation clear by cfg_load with a simultaneous bit
    send_bits(16'b101, 3, "clr_prefix");
    step(1'b1, 8'b0000_1011, 4, 1'b1, 1'b1, 1'b1, "clr_load");
    bit_in(1'b1, "clr_after");
    expect_det(1'b0, "clr_no_pulse");

    // mid-pattern reset
    load(8'b0000_1011, 4, 1'b1, "rst_prep");
    send_bits(16'b101, 3, "rst_prefix");
    do_reset();
    bit_in(1'b1, "rst_after");
    expect_det(1'b0, "rst_no_pulse");

    // saturation: five overlapping matches
    do_reset();
    send_bits(16'b101, 3, "sat_prefix");
    for (int m = 1; m <= 5; m++) begin
      bit_in(1'b1, "sat_match");
`ifdef SEQ_DET_MATCH_COUNT_EN
      expect_cnt((m < 3) ? m : 3, "sat_count");
`else
      expect_cnt(0, "sat_count_off");
`endif
      if (m < 5) send_bits(16'b01, 2, "sat_mid");
    end

    // randomized phase
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        logic [LEN_W-1:0] l;
        l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                        : LEN_W'($urandom_range(1, 4));
        step(1'b1, 8'($urandom), l, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_load");
      end else begin
        step(1'b0, 8'($urandom), LEN_W'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand_bit");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
